// File: rtl/hazard_pipe_ctrl_if.sv
// Pipeline control bundle between the ID decoder, the EX/MEM/WB datapath
// and hazard_pipe_ctrl. The master side drives the decoded ID fields and
// the EX redirect. The slave side is the pipeline controller.
interface hazard_pipe_ctrl_if;
  // Decoded ID-stage fields and EX redirect
  logic       id_branch, id_memread, id_add, id_memwrite, id_regwrite, id_immediate;
  logic [1:0] id_toreg, id_alusrc1, id_jump;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_redirect;

  // ID/EX stage fields
  logic       ex_branch, ex_memread, ex_add, ex_memwrite, ex_regwrite, ex_immediate;
  logic [1:0] ex_toreg, ex_alusrc1, ex_jump;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;

  // EX/MEM and MEM/WB stage fields
  logic       mem_memread, mem_memwrite, mem_regwrite;
  logic [1:0] mem_toreg;
  logic [4:0] mem_rd;
  logic       wb_regwrite;
  logic [1:0] wb_toreg;
  logic [4:0] wb_rd;

  // Hazard, forwarding and event counters
  logic        stall, flush_ifid;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  modport master (
    output id_branch, id_memread, id_add, id_memwrite, id_regwrite, id_immediate,
    output id_toreg, id_alusrc1, id_jump, id_rs1, id_rs2, id_rd, ex_redirect,
    input  ex_branch, ex_memread, ex_add, ex_memwrite, ex_regwrite, ex_immediate,
    input  ex_toreg, ex_alusrc1, ex_jump, ex_rs1, ex_rs2, ex_rd,
    input  mem_memread, mem_memwrite, mem_regwrite, mem_toreg, mem_rd,
    input  wb_regwrite, wb_toreg, wb_rd,
    input  stall, flush_ifid, fwd_a, fwd_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_branch, id_memread, id_add, id_memwrite, id_regwrite, id_immediate,
    input  id_toreg, id_alusrc1, id_jump, id_rs1, id_rs2, id_rd, ex_redirect,
    output ex_branch, ex_memread, ex_add, ex_memwrite, ex_regwrite, ex_immediate,
    output ex_toreg, ex_alusrc1, ex_jump, ex_rs1, ex_rs2, ex_rd,
    output mem_memread, mem_memwrite, mem_regwrite, mem_toreg, mem_rd,
    output wb_regwrite, wb_toreg, wb_rd,
    output stall, flush_ifid, fwd_a, fwd_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_pipe_ctrl.sv
// Carries decoded control through ID/EX, EX/MEM and MEM/WB. Stalls on
// load-use hazards, squashes the ID instruction on an EX redirect, and
// produces the EX operand forwarding selects.
module hazard_pipe_ctrl (
  input  logic               clk,
  input  logic               reset,
  hazard_pipe_ctrl_if.slave  p
);

  typedef struct packed {
    logic       branch, memread, add, memwrite, regwrite, immediate;
    logic [1:0] toreg, alusrc1, jump;
    logic [4:0] rs1, rs2, rd;
  } idex_t;

  typedef struct packed {
    logic       memread, memwrite, regwrite;
    logic [1:0] toreg;
    logic [4:0] rd;
  } exmem_t;

  typedef struct packed {
    logic       regwrite;
    logic [1:0] toreg;
    logic [4:0] rd;
  } memwb_t;

  idex_t       id_word;
  idex_t       idex_q, idex_d;
  exmem_t      exmem_q, exmem_d;
  memwb_t      memwb_q, memwb_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic rs1_used, rs2_used, hazard, stall;

  // Load-use detection on the ID instruction against the load in EX
  always_comb begin
    id_word  = {p.id_branch, p.id_memread, p.id_add, p.id_memwrite, p.id_regwrite,
                p.id_immediate, p.id_toreg, p.id_alusrc1, p.id_jump,
                p.id_rs1, p.id_rs2, p.id_rd};
    rs1_used = p.id_branch | ((p.id_alusrc1 == 2'b00) & (p.id_jump != 2'b01));
    rs2_used = p.id_branch | p.id_memwrite | ~p.id_immediate;
    hazard   = idex_q.memread & (idex_q.rd != 5'd0) &
               ((rs1_used & (idex_q.rd == p.id_rs1)) |
                (rs2_used & (idex_q.rd == p.id_rs2)));
    // A redirect makes the ID instruction wrong-path, so it never stalls.
    stall    = hazard & ~p.ex_redirect;
  end

  // Next-state of the stage registers and saturating event counters
  always_comb begin
    idex_d  = (stall | p.ex_redirect) ? '0 : id_word;
    exmem_d = {idex_q.memread, idex_q.memwrite, idex_q.regwrite, idex_q.toreg, idex_q.rd};
    memwb_d = {exmem_q.regwrite, exmem_q.toreg, exmem_q.rd};
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 16'd1;
    if (p.ex_redirect && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  // Stage registers and counters, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q      <= '0;
      exmem_q     <= '0;
      memwb_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      idex_q      <= idex_d;
      exmem_q     <= exmem_d;
      memwb_q     <= memwb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // EX operand select: EX/MEM result wins over MEM/WB; x0 never forwards
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (exmem_q.regwrite && (exmem_q.rd != 5'd0) && (exmem_q.rd == rs))
      return 2'b10;
    else if (memwb_q.regwrite && (memwb_q.rd != 5'd0) && (memwb_q.rd == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign p.fwd_a        = fwd_sel(idex_q.rs1);
  assign p.fwd_b        = fwd_sel(idex_q.rs2);
  assign p.stall        = stall;
  assign p.flush_ifid   = p.ex_redirect;
  assign p.stall_cnt    = stall_cnt_q;
  assign p.flush_cnt    = flush_cnt_q;

  assign p.ex_branch    = idex_q.branch;
  assign p.ex_memread   = idex_q.memread;
  assign p.ex_add       = idex_q.add;
  assign p.ex_memwrite  = idex_q.memwrite;
  assign p.ex_regwrite  = idex_q.regwrite;
  assign p.ex_immediate = idex_q.immediate;
  assign p.ex_toreg     = idex_q.toreg;
  assign p.ex_alusrc1   = idex_q.alusrc1;
  assign p.ex_jump      = idex_q.jump;
  assign p.ex_rs1       = idex_q.rs1;
  assign p.ex_rs2       = idex_q.rs2;
  assign p.ex_rd        = idex_q.rd;

  assign p.mem_memread  = exmem_q.memread;
  assign p.mem_memwrite = exmem_q.memwrite;
  assign p.mem_regwrite = exmem_q.regwrite;
  assign p.mem_toreg    = exmem_q.toreg;
  assign p.mem_rd       = exmem_q.rd;

  assign p.wb_regwrite  = memwb_q.regwrite;
  assign p.wb_toreg     = memwb_q.toreg;
  assign p.wb_rd        = memwb_q.rd;

endmodule
